// File: rtl/interval_timer_ctrl_pkg.sv
// Shared definitions for the interval timer controller: FSM state encodings
// and the state width exported on the debug port.
package timer_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Command/status bundle between control logic (master) and the interval
// timer controller (slave).
interface interval_timer_ctrl_if
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic               start;
  logic               pause;
  logic               abort;
  logic               periodic;
  logic [WIDTH-1:0]   period;
  logic [WIDTH-1:0]   count;
  logic               busy;
  logic               paused;
  logic               done;
  logic               err;
  logic [STATE_W-1:0] state;

  modport master (
    output start, pause, abort, periodic, period,
    input  count, busy, paused, done, err, state
  );

  modport slave (
    input  start, pause, abort, periodic, period,
    output count, busy, paused, done, err, state
  );

endinterface

// File: rtl/interval_timer_ctrl_counter.sv
// WIDTH-bit up-counter owned by the interval timer FSM; clear wins over enable.
module ctl_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= r_q + WIDTH'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer FSM: sequences ctl_counter through start/pause/abort and
// terminal count, in one-shot or auto-reload mode, with registered done/err pulses.
module interval_timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  interval_timer_ctrl_if.slave bus
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_period;
  logic             r_mode;
  logic             r_done;
  logic             r_err;

  logic             w_clr;
  logic             w_en;
  logic             w_capture;
  logic             w_done_d;
  logic             w_err_d;
  logic             w_term;
  logic [WIDTH-1:0] w_count;

  ctl_counter #(.WIDTH(WIDTH)) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .en    (w_en),
    .q     (w_count)
  );

  // period 0 is never captured, so period_q-1 cannot wrap while busy
  assign w_term = (w_count == (r_period - WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_period <= '0;
      r_mode   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_period <= bus.period;
        r_mode   <= bus.periodic;
      end
      r_done <= w_done_d;
      r_err  <= w_err_d;
    end
  end

  // abort > pause > terminal count > start; a paused cycle never counts
  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    w_en         = 1'b0;
    w_capture    = 1'b0;
    w_done_d     = 1'b0;
    w_err_d      = 1'b0;
    if (bus.abort) begin
      w_next_state = S_IDLE;
      w_clr        = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.period != '0) begin
              w_capture    = 1'b1;
              w_clr        = 1'b1;
              w_next_state = S_RUN;
            end else begin
              w_err_d = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.pause) begin
            w_next_state = S_PAUSE;
          end else if (w_term) begin
            w_done_d     = 1'b1;
            w_clr        = 1'b1;
            w_next_state = r_mode ? S_RUN : S_IDLE;
          end else begin
            w_en = 1'b1;
          end
        end
        S_PAUSE: begin
          if (!bus.pause) begin
            w_next_state = S_RUN;
          end
        end
        default: begin
          w_next_state = S_IDLE;
          w_clr        = 1'b1;
        end
      endcase
    end
  end

  assign bus.count  = w_count;
  assign bus.busy   = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign bus.paused = (r_state == S_PAUSE);
  assign bus.done   = r_done;
  assign bus.err    = r_err;
  assign bus.state  = r_state;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl (WIDTH=4) with hand-computed expectations.
module tb_interval_timer_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  interval_timer_ctrl_if #(.WIDTH(4)) bus ();

  interval_timer_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock edge, then settle before sampling or changing inputs
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.abort    = 1'b0;
    bus.periodic = 1'b0;
    bus.period   = 4'd0;
    step();
    step();
    chk("rst_state",  32'(bus.state),  0);
    chk("rst_count",  32'(bus.count),  0);
    chk("rst_busy",   32'(bus.busy),   0);
    chk("rst_paused", 32'(bus.paused), 0);
    chk("rst_done",   32'(bus.done),   0);
    chk("rst_err",    32'(bus.err),    0);
    reset = 1'b0;

    // reset mid-RUN at count=5, P=9
    bus.period = 4'd9; bus.periodic = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("mid_count", 32'(bus.count), 5);
    reset = 1'b1;
    step();
    chk("mrst_count", 32'(bus.count), 0);
    chk("mrst_state", 32'(bus.state), 0);
    chk("mrst_busy",  32'(bus.busy),  0);
    chk("mrst_done",  32'(bus.done),  0);
    reset = 1'b0;

    // one-shot P=5 with back-to-back restart in the done cycle
    bus.period = 4'd5; bus.periodic = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("os_c0",    32'(bus.count), 0);
    chk("os_busy0", 32'(bus.busy),  1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("os_c%0d", k), 32'(bus.count), 32'(k));
      chk($sformatf("os_d%0d", k), 32'(bus.done),  0);
    end
    step();
    chk("os_done",  32'(bus.done),  1);
    chk("os_busy5", 32'(bus.busy),  0);
    chk("os_cnt5",  32'(bus.count), 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("os_rs_busy", 32'(bus.busy),  1);
    chk("os_rs_cnt",  32'(bus.count), 0);
    chk("os_rs_done", 32'(bus.done),  0);
    do_abort();

    // periodic P=3; start with new period/mode while running is ignored
    bus.period = 4'd3; bus.periodic = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i >= 4 && i <= 6) begin
        bus.start = 1'b1; bus.period = 4'd7; bus.periodic = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
      step();
      chk($sformatf("per_c%0d", i), 32'(bus.count), 32'(i % 3));
      chk($sformatf("per_d%0d", i), 32'(bus.done),  32'(i % 3 == 0));
      chk($sformatf("per_s%0d", i), 32'(bus.state), 1);
    end
    bus.start = 1'b0;
    do_abort();

    // periodic P=6, pause high for three edges starting at count=3
    bus.period = 4'd6; bus.periodic = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("pz_pre", 32'(bus.count), 3);
    bus.pause = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("pz_st%0d", j), 32'(bus.state),  2);
      chk($sformatf("pz_c%0d", j),  32'(bus.count),  3);
      chk($sformatf("pz_p%0d", j),  32'(bus.paused), 1);
    end
    bus.pause = 1'b0;
    step();
    chk("pz_resume_st", 32'(bus.state), 1);
    chk("pz_resume_c",  32'(bus.count), 3);
    step();
    chk("pz_c4", 32'(bus.count), 4);
    step();
    chk("pz_c5", 32'(bus.count), 5);
    chk("pz_d5", 32'(bus.done),  0);
    step();
    chk("pz_done", 32'(bus.done), 1);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("pz_nd%0d", k), 32'(bus.done), 0);
    end
    step();
    chk("pz_done2", 32'(bus.done), 1);
    do_abort();

    // abort with start at count=2, then abort+start in IDLE, then period=0
    bus.period = 4'd4; bus.periodic = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("ab_pre", 32'(bus.count), 2);
    bus.abort = 1'b1; bus.start = 1'b1;
    step();
    chk("ab_state", 32'(bus.state), 0);
    chk("ab_count", 32'(bus.count), 0);
    chk("ab_done",  32'(bus.done),  0);
    step();
    chk("ab_idle_busy", 32'(bus.busy), 0);
    bus.abort = 1'b0; bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("ab_nd%0d", k), 32'(bus.done), 0);
    end
    bus.period = 4'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("err_pulse", 32'(bus.err),  1);
    chk("err_busy",  32'(bus.busy), 0);
    step();
    chk("err_clr",   32'(bus.err),  0);
    chk("err_busy2", 32'(bus.busy), 0);

    // P=1 periodic: done every cycle, count stuck at 0
    bus.period = 4'd1; bus.periodic = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("p1_d0", 32'(bus.done), 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("p1_d%0d", i), 32'(bus.done),  1);
      chk($sformatf("p1_c%0d", i), 32'(bus.count), 0);
      chk($sformatf("p1_b%0d", i), 32'(bus.busy),  1);
    end
    do_abort();

    // P=15 one-shot: maximum period, no overflow
    bus.period = 4'd15; bus.periodic = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      chk($sformatf("p15_c%0d", k), 32'(bus.count), 32'(k));
      chk($sformatf("p15_d%0d", k), 32'(bus.done),  0);
    end
    step();
    chk("p15_done",  32'(bus.done),  1);
    chk("p15_count", 32'(bus.count), 0);
    chk("p15_busy",  32'(bus.busy),  0);
    step();
    chk("p15_done_off", 32'(bus.done), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
